conv_mac_sequencer: RTL and testbench
=====================================

Name: conv_mac_sequencer

Overview:
- Sequences one shared signed MAC cell over a TAPS-tap convolution window.
- Holds the window weights in a local register file, accepts a pixel stream via valid/ready, and drives din/wt/sumin to the external MAC cell.
- Feeds the MAC's registered sumout back as the running sum and emits one signed sum per window via valid/ready.
- Sits between the pixel line buffer and the feature-map writer.

Parameters:
- TAPS, 9, window taps per output sum (3x3 kernel); legal range 2..16.
- DW, 9, signed pixel/weight width.
- SW, 18, signed accumulator width; must match the MAC cell.
- AW, 4, weight address width; 2^AW >= TAPS.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- run  in  1  level; 1 = process windows, 0 = return to IDLE after current result drains
- cfg_we  in  1  weight write strobe (honoured only in IDLE)
- cfg_addr  in  AW  weight index
- cfg_data  in  DW  signed weight
- pix_valid  in  1  pixel available
- pix_data  in  DW  signed pixel
- pix_ready  out  1  sequencer accepts pixel this cycle
- mac_din  out  DW  to MAC din
- mac_wt  out  DW  to MAC wt
- mac_sumin  out  SW  to MAC sumin
- mac_sumout  in  SW  from MAC sumout (1-cycle registered)
- res_valid  out  1  result available
- res_data  out  SW  signed window sum
- res_ready  in  1  consumer accepts result
- busy  out  1  state != IDLE
- res_count  out  16  results delivered, wraps at 2^16

Behaviour:
- Reset (synchronous, active-high; clock clock): state=IDLE, tap=0, weights cleared to 0, res_valid=0, res_data=0, res_count=0. Reset wins over every other input on the same edge and aborts any partial window; the partial sum is discarded.
- States: IDLE, ACC, WAIT, OUT.
- IDLE:
  - pix_ready=0.
  - cfg_we=1 with cfg_addr<TAPS writes w[cfg_addr]<=cfg_data; cfg_addr>=TAPS is ignored.
  - run=1 and cfg_we=0 -> ACC with tap=0. If cfg_we=1 in the same cycle, the write happens and the state stays IDLE.
- ACC:
  - pix_ready=1 combinationally.
  - Handshake (pix_valid&pix_ready) issues one tap: mac_din=pix_data, mac_wt=w[tap], mac_sumin=0 if tap==0 else mac_sumout. The tap increments.
  - Handshake with tap==TAPS-1 -> WAIT.
  - No handshake (stall): mac_din=0, mac_wt=0, mac_sumin=mac_sumout, so the MAC holds the partial sum. The tap is unchanged. Stalls of any length are legal.
- WAIT:
  - pix_ready=0; MAC driven with the hold pattern.
  - res_data<=mac_sumout (final sum), res_valid<=1 -> OUT.
- OUT:
  - pix_ready=0; MAC driven with hold.
  - res_valid and res_data stay stable until res_ready=1.
  - On res_valid&res_ready: res_valid<=0, res_count++. Go to ACC (tap=0) if run=1, else IDLE.
- In IDLE, mac_din=0, mac_wt=0, mac_sumin=0.
- Latency: last pixel handshake at cycle t; res_valid=1 from cycle t+2.
- Throughput: TAPS+2 cycles per window with no stalls and res_ready held at 1.
- Arithmetic: the product and sum are computed in the MAC at SW bits. They wrap modulo 2^SW with no saturation or overflow flag; the sequencer passes values unchanged.
- run deasserted mid-window: the window completes, then IDLE after the result drains.
- cfg_we outside IDLE: ignored, weights unchanged.
- busy is registered and equals (state != IDLE).

Test Plan:
- Sum check: TAPS=9, all weights 1, pixels 1..9 back-to-back, res_ready=1 -> res_data=45 at 2 cycles after the 9th handshake; res_count=1.
- Signed/wrap: weights all -256, pixels all -256 -> each product 65536. Sum 589824 wraps mod 2^18 -> res_data=65536. Then weights {-1,2,0,...,0}, pixels {5,3,...} -> res_data=1.
- Stalls: pix_valid low for 3 cycles between taps 4 and 5, weights 1, pixels 1..9 -> res_data=45 unchanged; no tap skipped or repeated.
- Backpressure: res_ready low for 5 cycles -> res_valid and res_data held, pix_ready=0 throughout. Second window starts only after the accept; res_count increments once.
- Config guard: cfg_we in ACC writing w[0]=7 -> ignored and window sum unchanged. In IDLE, cfg_addr=12 is ignored and w[0]=7 is stored.
- Reset mid-window after 4 taps -> next cycle state IDLE, pix_ready=0, res_valid=0, weights=0. A rerun with reloaded weights yields the correct full-window sum.

Source files
------------

// File: rtl/conv_mac_sequencer.sv
// rtl/conv_mac_sequencer.sv - drives one shared signed MAC cell across a TAPS-tap convolution window
module conv_mac_sequencer #(
   parameter int TAPS = 9,
   parameter int DW   = 9,
   parameter int SW   = 18,
   parameter int AW   = 4
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 run,
   input  logic                 cfg_we,
   input  logic [AW-1:0]        cfg_addr,
   input  logic signed [DW-1:0] cfg_data,
   input  logic                 pix_valid,
   input  logic signed [DW-1:0] pix_data,
   output logic                 pix_ready,
   output logic signed [DW-1:0] mac_din,
   output logic signed [DW-1:0] mac_wt,
   output logic signed [SW-1:0] mac_sumin,
   input  logic signed [SW-1:0] mac_sumout,
   output logic                 res_valid,
   output logic signed [SW-1:0] res_data,
   input  logic                 res_ready,
   output logic                 busy,
   output logic [15:0]          res_count
);

   typedef enum logic [1:0] {IDLE, ACC, WAIT, OUT} state_t;

   localparam logic [AW-1:0] LAST_TAP = AW'(TAPS - 1);
   localparam logic [AW:0]   TAPS_LIM = (AW + 1)'(TAPS);

   state_t               state, state_next;
   logic [AW-1:0]        tap;
   logic signed [DW-1:0] w [2**AW];
   logic                 pix_fire;
   logic                 res_fire;
   logic                 cfg_fire;

   assign pix_ready = (state == ACC);
   assign pix_fire  = pix_valid && (state == ACC);
   assign res_fire  = res_valid && res_ready;
   assign cfg_fire  = (state == IDLE) && cfg_we && ({1'b0, cfg_addr} < TAPS_LIM);

   // Outside a tap issue the MAC recirculates its own sum, so stalls cost nothing.
   always_comb begin
      state_next = state;
      mac_din    = '0;
      mac_wt     = '0;
      mac_sumin  = mac_sumout;
      case (state)
         IDLE: begin
            mac_sumin = '0;
            if (run && !cfg_we) state_next = ACC;
         end
         ACC: begin
            if (pix_fire) begin
               mac_din   = pix_data;
               mac_wt    = w[tap];
               mac_sumin = (tap == '0) ? '0 : mac_sumout;
               if (tap == LAST_TAP) state_next = WAIT;
            end
         end
         WAIT: state_next = OUT;
         OUT: begin
            if (res_fire) state_next = run ? ACC : IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= IDLE;
         busy      <= 1'b0;
         tap       <= '0;
         res_valid <= 1'b0;
         res_data  <= '0;
         res_count <= '0;
         for (int i = 0; i < 2**AW; i++) w[i] <= '0;
      end else begin
         state <= state_next;
         busy  <= (state_next != IDLE);
         if (cfg_fire) w[cfg_addr] <= cfg_data;
         if (state != ACC) tap <= '0;
         else if (pix_fire) tap <= (tap == LAST_TAP) ? '0 : tap + 1'b1;
         // The MAC output register holds the final sum during WAIT.
         if (state == WAIT) begin
            res_valid <= 1'b1;
            res_data  <= mac_sumout;
         end else if (res_fire) begin
            res_valid <= 1'b0;
            res_count <= res_count + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_conv_mac_sequencer.sv
// tb/tb_conv_mac_sequencer.sv - self-checking bench for conv_mac_sequencer with a window-sum reference model
module tb_conv_mac_sequencer;

   localparam int TAPS = 9;
   localparam int DW   = 9;
   localparam int SW   = 18;
   localparam int AW   = 4;

   logic                 clock = 1'b0;
   logic                 reset = 1'b1;
   logic                 run = 1'b0;
   logic                 cfg_we = 1'b0;
   logic [AW-1:0]        cfg_addr = '0;
   logic signed [DW-1:0] cfg_data = '0;
   logic                 pix_valid = 1'b0;
   logic signed [DW-1:0] pix_data = '0;
   logic                 pix_ready;
   logic signed [DW-1:0] mac_din;
   logic signed [DW-1:0] mac_wt;
   logic signed [SW-1:0] mac_sumin;
   logic signed [SW-1:0] mac_sumout = '0;
   logic                 res_valid;
   logic signed [SW-1:0] res_data;
   logic                 res_ready = 1'b1;
   logic                 busy;
   logic [15:0]          res_count;

   int n_assert = 0;
   int n_fail   = 0;

   int mw [TAPS];
   int win [$];
   int expq [$];
   int exp_count = 0;
   int last_res = 0;
   int pbuf [TAPS];
   bit rand_mode = 1'b0;
   bit held_prev = 1'b0;
   int prev_data = 0;

   conv_mac_sequencer #(.TAPS(TAPS), .DW(DW), .SW(SW), .AW(AW)) dut (
      .clock(clock), .reset(reset), .run(run),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
      .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
      .mac_din(mac_din), .mac_wt(mac_wt), .mac_sumin(mac_sumin), .mac_sumout(mac_sumout),
      .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
      .busy(busy), .res_count(res_count)
   );

   always #5 clock = ~clock;

   // External MAC cell: registered sumin + din*wt, wrapping at SW bits.
   always @(posedge clock) mac_sumout <= mac_sumin + mac_din * mac_wt;

   task automatic chk(input string name, input int act, input int exp);
      n_assert++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int window_sum();
      longint s = 0;
      logic signed [SW-1:0] r;
      for (int i = 0; i < TAPS; i++) s += longint'(mw[i]) * longint'(win[i]);
      r = s[SW-1:0];
      return int'(r);
   endfunction

   // Reference model and per-cycle checker.
   always @(negedge clock) begin
      if (reset) begin
         win.delete();
         expq.delete();
         exp_count = 0;
         held_prev = 1'b0;
      end else begin
         chk("ready_vs_valid_exclusive", int'(pix_ready && res_valid), 0);
         if (pix_ready || res_valid) chk("busy_when_active", int'(busy), 1);
         if (held_prev) begin
            chk("res_valid_held", int'(res_valid), 1);
            chk("res_data_held", int'(res_data), prev_data);
         end
         if (pix_valid && pix_ready) begin
            win.push_back(int'(pix_data));
            if (win.size() == TAPS) begin
               expq.push_back(window_sum());
               win.delete();
            end
         end
         if (res_valid) begin
            chk("res_count", int'(res_count), exp_count);
            if (res_ready) begin
               if (expq.size() == 0) chk("unexpected_result", int'(res_data), -999999);
               else chk("res_data", int'(res_data), expq.pop_front());
               last_res  = int'(res_data);
               exp_count = (exp_count + 1) & 16'hffff;
               held_prev = 1'b0;
            end else begin
               held_prev = 1'b1;
               prev_data = int'(res_data);
            end
         end else begin
            held_prev = 1'b0;
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
      if (rand_mode) res_ready = ($urandom_range(0, 3) != 0);
   endtask

   task automatic write_w(input int addr, input int data, input bit honour);
      cfg_we   = 1'b1;
      cfg_addr = AW'(addr);
      cfg_data = DW'(data);
      tick();
      cfg_we = 1'b0;
      if (honour && addr < TAPS) mw[addr] = data;
   endtask

   task automatic set_all(input int v);
      for (int i = 0; i < TAPS; i++) write_w(i, v, 1'b1);
   endtask

   task automatic send_pix(input int v, output int waited);
      int n = 0;
      pix_valid = 1'b1;
      pix_data  = DW'(v);
      while (!pix_ready && n < 100) begin
         tick();
         n++;
      end
      chk("pix_accept_in_time", int'(n < 100), 1);
      tick();
      pix_valid = 1'b0;
      waited = n;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 200) begin
         tick();
         n++;
      end
      chk("idle_reached", int'(busy), 0);
   endtask

   task automatic run_window(input int stall_at, input int stall_len, input bit rnd);
      int wt;
      run = 1'b1;
      tick();
      for (int i = 0; i < TAPS; i++) begin
         if (i == stall_at) repeat (stall_len) tick();
         if (rnd) repeat ($urandom_range(0, 2)) tick();
         send_pix(pbuf[i], wt);
         run = 1'b0;
      end
      wait_idle();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      int wt;
      for (int i = 0; i < TAPS; i++) mw[i] = 0;
      tick();
      tick();
      reset = 1'b0;
      chk("rst_pix_ready", int'(pix_ready), 0);
      chk("rst_res_valid", int'(res_valid), 0);
      chk("rst_res_data", int'(res_data), 0);
      chk("rst_res_count", int'(res_count), 0);
      chk("rst_busy", int'(busy), 0);

      // Basic sum with latency check
      set_all(1);
      for (int i = 0; i < TAPS; i++) pbuf[i] = i + 1;
      run = 1'b1;
      tick();
      for (int i = 0; i < TAPS; i++) send_pix(pbuf[i], wt);
      chk("latency_wait_cycle", int'(res_valid), 0);
      tick();
      chk("latency_out_cycle", int'(res_valid), 1);
      chk("sum_45", int'(res_data), 45);
      run = 1'b0;
      wait_idle();
      chk("count_after_first", int'(res_count), 1);

      // Signed products and modular wrap
      set_all(-256);
      for (int i = 0; i < TAPS; i++) pbuf[i] = -256;
      run_window(-1, 0, 1'b0);
      chk("wrap_65536", last_res, 65536);
      set_all(0);
      write_w(0, -1, 1'b1);
      write_w(1, 2, 1'b1);
      pbuf[0] = 5;
      pbuf[1] = 3;
      for (int i = 2; i < TAPS; i++) pbuf[i] = int'($urandom_range(0, 511)) - 256;
      run_window(-1, 0, 1'b0);
      chk("signed_sum_1", last_res, 1);

      // Stall between taps 4 and 5
      set_all(1);
      for (int i = 0; i < TAPS; i++) pbuf[i] = i + 1;
      run_window(4, 3, 1'b0);
      chk("stall_sum_45", last_res, 45);

      // Back-to-back windows: TAPS+2 cycles per window
      run = 1'b1;
      tick();
      for (int i = 0; i < 2 * TAPS; i++) begin
         send_pix(int'($urandom_range(0, 511)) - 256, wt);
         chk("throughput_wait", wt, (i == TAPS) ? 2 : 0);
         if (i == TAPS) run = 1'b0;
      end
      wait_idle();

      // Result backpressure
      for (int i = 0; i < TAPS; i++) pbuf[i] = i + 1;
      res_ready = 1'b0;
      run = 1'b1;
      tick();
      for (int i = 0; i < TAPS; i++) send_pix(pbuf[i], wt);
      begin
         int n = 0;
         while (!res_valid && n < 20) begin
            tick();
            n++;
         end
      end
      chk("bp_res_valid_seen", int'(res_valid), 1);
      pix_valid = 1'b1;
      pix_data  = DW'(pbuf[0]);
      repeat (5) begin
         tick();
         chk("bp_valid_held", int'(res_valid), 1);
         chk("bp_pix_ready_low", int'(pix_ready), 0);
         chk("bp_data_45", int'(res_data), 45);
         chk("bp_count_unchanged", int'(res_count), exp_count);
      end
      res_ready = 1'b1;
      for (int i = 0; i < TAPS; i++) begin
         send_pix(pbuf[i], wt);
         run = 1'b0;
      end
      wait_idle();
      chk("bp_second_sum_45", last_res, 45);

      // Config writes outside IDLE are ignored
      set_all(1);
      run = 1'b1;
      tick();
      for (int i = 0; i < TAPS; i++) begin
         if (i == 3) begin
            cfg_we   = 1'b1;
            cfg_addr = '0;
            cfg_data = 9'sd7;
            tick();
            cfg_we = 1'b0;
         end
         send_pix(i + 1, wt);
         run = 1'b0;
      end
      wait_idle();
      chk("cfg_in_acc_ignored", last_res, 45);
      write_w(12, 99, 1'b0);
      cfg_we   = 1'b1;
      cfg_addr = '0;
      cfg_data = 9'sd7;
      run      = 1'b1;
      tick();
      mw[0]    = 7;
      cfg_we   = 1'b0;
      run      = 1'b0;
      chk("cfg_with_run_stays_idle", int'(busy), 0);
      for (int i = 0; i < TAPS; i++) pbuf[i] = 1;
      run_window(-1, 0, 1'b0);
      chk("cfg_idle_sum_15", last_res, 15);

      // Reset mid-window
      run = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) begin
         send_pix(i + 1, wt);
         run = 1'b0;
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int i = 0; i < TAPS; i++) mw[i] = 0;
      chk("midrst_pix_ready", int'(pix_ready), 0);
      chk("midrst_res_valid", int'(res_valid), 0);
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_count", int'(res_count), 0);
      for (int i = 0; i < TAPS; i++) pbuf[i] = i + 1;
      run_window(-1, 0, 1'b0);
      chk("midrst_weights_zero", last_res, 0);
      set_all(2);
      run_window(-1, 0, 1'b0);
      chk("midrst_rerun_90", last_res, 90);

      // Randomized windows with stalls and backpressure
      for (int k = 0; k < 15; k++) begin
         for (int i = 0; i < TAPS; i++) write_w(i, int'($urandom_range(0, 511)) - 256, 1'b1);
         write_w(TAPS + int'($urandom_range(0, 15 - TAPS)), int'($urandom_range(0, 255)), 1'b1);
         for (int i = 0; i < TAPS; i++) pbuf[i] = int'($urandom_range(0, 511)) - 256;
         rand_mode = 1'b1;
         run_window(-1, 0, 1'b1);
         rand_mode = 1'b0;
         res_ready = 1'b1;
      end

      chk("no_pending_results", expq.size(), 0);
      chk("no_partial_window", win.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
